// File: rtl/systolic_skew_feeder.sv
// Edge feeder for a DIMxDIM systolic mesh: buffers one operand tile, clears the
// PE accumulators, streams the tile with lane k delayed k beats, drains with zeros.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DIM*DATA_WIDTH-1:0] in_data_i,
    output logic                      out_valid_o,
    output logic [DIM*DATA_WIDTH-1:0] out_data_o,
    output logic                      pe_clr_o,
    output logic                      done_o
);

    localparam int CW = $clog2(2 * DIM) + 1;
    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [CW-1:0] LAST_VEC    = CW'(DIM - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(2 * DIM - 2);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'((DIM > 1) ? DIM - 2 : 0);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [CW-1:0]               vcnt_reg, vcnt_next;
    logic [CW-1:0]               beat_reg, beat_next;
    logic                        in_reset_reg;
    logic                        load_en;
    logic [DIM*DATA_WIDTH-1:0]   buf_reg [DIM];

    // in_reset_reg keeps in_ready_o low for the whole reset window, not just
    // the first reset edge, without a combinational path from rst_i.
    assign in_ready_o  = (state_reg == S_LOAD) && !in_reset_reg;
    assign out_valid_o = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
    assign pe_clr_o    = (state_reg == S_CLEAR);
    assign done_o      = (state_reg == S_DONE);

    always_comb begin
        state_next = state_reg;
        vcnt_next  = vcnt_reg;
        beat_next  = beat_reg;
        load_en    = 1'b0;
        case (state_reg)
            S_LOAD: begin
                if (in_valid_i && in_ready_o) begin
                    load_en = 1'b1;
                    if (vcnt_reg == LAST_VEC) begin
                        vcnt_next  = '0;
                        state_next = S_CLEAR;
                    end else begin
                        vcnt_next = vcnt_reg + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                beat_next  = '0;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (beat_reg == STREAM_LAST) begin
                    beat_next  = '0;
                    state_next = (DIM > 1) ? S_DRAIN : S_DONE;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (beat_reg == DRAIN_LAST) begin
                    beat_next  = '0;
                    state_next = S_DONE;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_LOAD;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_LOAD;
            vcnt_reg     <= '0;
            beat_reg     <= '0;
            in_reset_reg <= 1'b1;
            for (int i = 0; i < DIM; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            vcnt_reg     <= vcnt_next;
            beat_reg     <= beat_next;
            in_reset_reg <= 1'b0;
            // Wiping on DONE keeps a finished tile from leaking into the next one.
            if (state_reg == S_DONE) begin
                for (int i = 0; i < DIM; i++) begin
                    buf_reg[i] <= '0;
                end
            end else if (load_en) begin
                buf_reg[vcnt_reg[AW-1:0]] <= in_data_i;
            end
        end
    end

    // Lane k shows vector (beat - k) while that index lies inside the tile.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            logic signed [CW:0] diff;
            logic               in_win;

            assign diff   = $signed({1'b0, beat_reg}) - $signed((CW + 1)'(gi));
            assign in_win = (state_reg == S_STREAM) && !diff[CW]
                            && (diff < $signed((CW + 1)'(DIM)));
            assign out_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
                in_win ? buf_reg[diff[AW-1:0]][gi*DATA_WIDTH +: DATA_WIDTH]
                       : '0;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (DIM=4, DATA_WIDTH=32): reset, skewed
// streaming, gapped loads, drain/done timing, mid-stream reset and back-to-back tiles.
module tb_systolic_skew_feeder;

    localparam int DW  = 32;
    localparam int DIM = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DIM*DW-1:0] in_data;
    logic              out_valid;
    logic [DIM*DW-1:0] out_data;
    logic              pe_clr;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DIM*DW-1:0] exp_base [7];

    systolic_skew_feeder #(
        .DATA_WIDTH(DW),
        .DIM       (DIM)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .pe_clr_o   (pe_clr),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DIM*DW-1:0] obs,
                       input logic [DIM*DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ctrl();
        return {in_ready, out_valid, pe_clr, done};
    endfunction

    function automatic logic [DIM*DW-1:0] mkvec(input int t, input logic [31:0] off);
        logic [DIM*DW-1:0] v;
        v = '0;
        for (int k = 0; k < DIM; k++) begin
            v[k*DW +: DW] = off + 32'(16 * (t + 1) + k);
        end
        return v;
    endfunction

    function automatic logic [DIM*DW-1:0] add_off(input logic [DIM*DW-1:0] base,
                                                  input logic [31:0] off);
        logic [DIM*DW-1:0] v;
        v = base;
        for (int k = 0; k < DIM; k++) begin
            if (base[k*DW +: DW] != 32'h0) v[k*DW +: DW] = base[k*DW +: DW] + off;
        end
        return v;
    endfunction

    // Starts in a LOAD cycle; returns sampled in the CLEAR cycle.
    task automatic load_tile(input logic [31:0] off, input bit gapped);
        logic [5:0] pat;
        int         steps;
        int         hs;
        pat   = gapped ? 6'b110101 : 6'b001111;
        steps = gapped ? 6 : 4;
        hs    = 0;
        for (int i = 0; i < steps; i++) begin
            chk("load_ready", {127'b0, in_ready}, 128'd1);
            in_valid = pat[i];
            in_data  = pat[i] ? mkvec(hs, off) : {DIM{32'hDEADBEEF}};
            tick();
            if (pat[i]) hs++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("clear_ctrl", {124'b0, ctrl()}, {124'b0, 4'b0010});
        chk("clear_data", out_data, '0);
    endtask

    // Starts sampled in CLEAR; returns sampled in the DONE cycle.
    task automatic stream_check(input logic [31:0] off, input bit hold_valid);
        in_valid = hold_valid;
        in_data  = {DIM{32'hBAADF00D}};
        for (int b = 0; b < 7; b++) begin
            tick();
            chk($sformatf("beat%0d_ctrl", b), {124'b0, ctrl()}, {124'b0, 4'b0100});
            chk($sformatf("beat%0d_data", b), out_data, add_off(exp_base[b], off));
        end
        for (int d = 0; d < 3; d++) begin
            tick();
            chk($sformatf("drain%0d_ctrl", d), {124'b0, ctrl()}, {124'b0, 4'b0100});
            chk($sformatf("drain%0d_data", d), out_data, '0);
        end
        tick();
        chk("done_ctrl", {124'b0, ctrl()}, {124'b0, 4'b0001});
        chk("done_data", out_data, '0);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        // lane3..lane0 of each skewed beat for tile t lane k = 0x10*(t+1)+k
        exp_base[0] = {32'h00, 32'h00, 32'h00, 32'h10};
        exp_base[1] = {32'h00, 32'h00, 32'h11, 32'h20};
        exp_base[2] = {32'h00, 32'h12, 32'h21, 32'h30};
        exp_base[3] = {32'h13, 32'h22, 32'h31, 32'h40};
        exp_base[4] = {32'h23, 32'h32, 32'h41, 32'h00};
        exp_base[5] = {32'h33, 32'h42, 32'h00, 32'h00};
        exp_base[6] = {32'h43, 32'h00, 32'h00, 32'h00};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held three cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset%0d_ctrl", i), {124'b0, ctrl()}, '0);
            chk($sformatf("reset%0d_data", i), out_data, '0);
        end
        rst = 1'b0;
        tick();
        chk("post_reset_ctrl", {124'b0, ctrl()}, {124'b0, 4'b1000});
        $display("txn reset: done");

        // Back-to-back load, skewed stream, drain and done.
        load_tile(32'h0, 1'b0);
        stream_check(32'h0, 1'b0);
        $display("txn tile0: streamed");

        // Second tile accepted in the cycle right after DONE.
        tick();
        load_tile(32'h100, 1'b0);
        stream_check(32'h100, 1'b0);
        $display("txn tile1 (+0x100): streamed back-to-back");

        // Gapped load, then in_valid held high through stream/drain/done.
        tick();
        load_tile(32'h0, 1'b1);
        stream_check(32'h0, 1'b1);
        $display("txn tile2 (gapped, valid held): streamed");

        // Mid-stream reset at beat t2.
        tick();
        load_tile(32'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("abort_beat2_data", out_data, exp_base[2]);
        rst = 1'b1;
        tick();
        chk("abort_reset_ctrl", {124'b0, ctrl()}, '0);
        chk("abort_reset_data", out_data, '0);
        rst = 1'b0;
        tick();
        chk("abort_release_ctrl", {124'b0, ctrl()}, {124'b0, 4'b1000});
        $display("txn tile3: aborted by reset at beat 2");

        load_tile(32'h200, 1'b0);
        stream_check(32'h200, 1'b0);
        $display("txn tile4 (+0x200): streamed after abort");

        tick();
        chk("final_idle_ctrl", {124'b0, ctrl()}, {124'b0, 4'b1000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
